// File: rtl/rscl_types.sv
// Shared types for the rscl core data path: machine word, data-port access size
// and the data-memory response record.
package rscl_types;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } dmem_size_t;

    typedef struct packed {
        logic  err;
        word_t data;
    } dmem_resp_t;

    // Byte-lane write strobe for an access of the given size at byte lane 'lane'.
    function automatic logic [3:0] lane_strobe(input dmem_size_t size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return 4'b0011 << lane;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic misaligned(input dmem_size_t size, input logic [1:0] lane);
        case (size)
            SZ_HALF: return lane[0];
            SZ_WORD: return |lane;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rscl_fifo.sv
// Synchronous FIFO with occupancy count; head entry is presented combinationally.
module rscl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        empty    = (count == '0);
        full     = (count == CW'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = store[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rscl_dmem.sv
// Data-memory responder: accepts d_a load/store requests against a word-addressed
// SRAM and returns one in-order d_d response (err, data) per request.
module rscl_dmem
    import rscl_types::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          RESP_DEPTH  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_a_valid,
    output logic        d_a_ready,
    input  logic        d_a_write,
    input  logic [1:0]  d_a_size,
    input  logic [31:0] d_a_addr,
    input  logic [31:0] d_a_wdata,
    output logic        d_d_valid,
    input  logic        d_d_ready,
    output logic        d_d_err,
    output logic [31:0] d_d_data
);

    localparam int          IW   = $clog2(DEPTH_WORDS);
    localparam int          CW   = $clog2(RESP_DEPTH + 1);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    word_t      mem [DEPTH_WORDS];
    dmem_size_t size;
    logic [32:0] offset;
    logic [IW-1:0] idx;
    logic [3:0] strb;
    logic       req_err;
    logic       accept;

    logic       s1_valid;
    dmem_resp_t s1_resp;
    dmem_resp_t q_head;
    logic       q_empty;
    logic [CW-1:0] q_count;

    // Range check done in 33 bits so addresses near either end never wrap.
    always_comb begin
        size    = dmem_size_t'(d_a_size);
        offset  = {1'b0, d_a_addr} - {1'b0, BASE_ADDR};
        idx     = offset[IW+1:2];
        strb    = lane_strobe(size, d_a_addr[1:0]);
        req_err = (size == SZ_RSVD) || misaligned(size, d_a_addr[1:0])
                  || (d_a_addr < BASE_ADDR) || (offset >= SPAN);
    end

    // s1 always drains into the queue next cycle, so counting it here keeps the
    // queue from ever overflowing without looking at d_d_ready.
    assign d_a_ready = !rst && ((int'(q_count) + int'(s1_valid)) < RESP_DEPTH);
    assign accept    = d_a_valid && d_a_ready;

    always_ff @(posedge clk) begin
        if (accept && d_a_write && !req_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (strb[b]) mem[idx][b*8 +: 8] <= d_a_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_resp  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_resp.err  <= req_err;
                s1_resp.data <= (!req_err && !d_a_write) ? mem[idx] : '0;
            end
        end
    end

    rscl_fifo #(
        .WIDTH ($bits(dmem_resp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_resp_q (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid),
        .push_data (s1_resp),
        .pop       (d_d_valid && d_d_ready),
        .pop_data  (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

    assign d_d_valid = !q_empty;
    assign d_d_err   = d_d_valid && q_head.err;
    assign d_d_data  = d_d_valid ? q_head.data : '0;

endmodule
